// File: rtl/analyzer_pkg.sv
// analyzer_pkg: shared FSM states and buffer geometry for the analyzer capture/readback paths
package analyzer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam longint MEMORY_CAPACITY = 64'd134217728;
  localparam int SAMPLE_PACKET_WIDTH = 32;
  localparam int NUM_PACKETS_DEFAULT = int'(MEMORY_CAPACITY / longint'(SAMPLE_PACKET_WIDTH / 8));
  localparam int MAX_OUTSTANDING_DEFAULT = 16;
endpackage

// File: rtl/analyzer_wrap_counter.sv
// analyzer_wrap_counter: loadable modulo-N counter that wraps from N-1 back to 0
module analyzer_wrap_counter #(
  parameter int N = 10,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (load) count <= load_val;
    else if (en) count <= (count == LAST) ? '0 : count + 1'b1;
endmodule

// File: rtl/analyzer_readback_ctrl.sv
// analyzer_readback_ctrl: walks a packet range of the circular capture buffer issuing credit-limited reads
module analyzer_readback_ctrl
  import analyzer_pkg::*;
#(
  parameter int NUM_PACKETS = NUM_PACKETS_DEFAULT,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  localparam int AW = $clog2(NUM_PACKETS),
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sampler_idle,
  input  logic          read_all,
  input  logic          abort,
  input  logic [AW-1:0] begin_num,
  input  logic [AW-1:0] end_num,
  output logic          req_valid,
  output logic [AW-1:0] req_addr,
  input  logic          req_ready,
  input  logic          rsp_valid,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          cfg_err,
  output logic          rsp_err,
  output logic [AW:0]   packets_issued
);
  localparam logic [AW:0] NP = (AW + 1)'(NUM_PACKETS);
  localparam logic [AW:0] ONE = (AW + 1)'(1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);
  state_t state, state_nxt;
  logic [AW:0] remaining, span, b_ext, e_ext;
  logic [OW-1:0] outstanding;
  logic armed, fire, accept, range_ok, rsp_ok, last_rsp, go_drain;
  assign b_ext = {1'b0, begin_num};
  assign e_ext = {1'b0, end_num};
  assign range_ok = (b_ext < NP) && (read_all || e_ext < NP);
  assign span = ((e_ext >= b_ext) ? e_ext - b_ext : e_ext + NP - b_ext) + ONE;
  assign rsp_ok = rsp_valid && outstanding != '0;
  assign last_rsp = (outstanding == '0) || (outstanding == OW'(1) && rsp_valid);
  assign fire = req_valid && req_ready;
  assign go_drain = abort || (fire && remaining == ONE);
  always_comb begin
    req_valid = (state == RUN) && (outstanding < MAX_OS);
    accept = (state == IDLE) && start && sampler_idle && range_ok;
    cfg_err = (state == IDLE) && start && sampler_idle && !range_ok;
    busy = state != IDLE;
    done = (state == DRAIN) && last_rsp;
    state_nxt = (state == IDLE) ? (accept ? RUN : IDLE) :
                (state == RUN) ? (go_drain ? DRAIN : RUN) :
                (last_rsp ? IDLE : DRAIN);
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // armed keeps stale responses from a pre-reset readback out of rsp_err
  always_ff @(posedge clk)
    if (reset) begin
      outstanding <= '0;
      remaining <= '0;
      packets_issued <= '0;
      aborted <= 1'b0;
      rsp_err <= 1'b0;
      armed <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(fire) - OW'(rsp_ok);
      if (fire) begin
        remaining <= remaining - ONE;
        packets_issued <= packets_issued + ONE;
      end
      if (abort && (state == RUN || (state == DRAIN && remaining != '0))) aborted <= 1'b1;
      if (rsp_valid && outstanding == '0 && armed) rsp_err <= 1'b1;
      if (accept) begin
        remaining <= read_all ? NP : span;
        packets_issued <= '0;
        aborted <= 1'b0;
        rsp_err <= 1'b0;
        armed <= 1'b1;
      end
    end
  analyzer_wrap_counter #(.N(NUM_PACKETS), .W(AW)) u_addr (
    .clk(clk),
    .reset(reset),
    .load(accept),
    .en(fire),
    .load_val(begin_num),
    .count(req_addr)
  );
endmodule

// File: tb/tb_analyzer_readback_ctrl.sv
// tb_analyzer_readback_ctrl: scoreboard bench for the readback sequencer on a 10-packet buffer
module tb_analyzer_readback_ctrl;
  localparam int NP = 10;
  logic clk = 0, reset = 1, start = 0, sampler_idle = 1, read_all = 0, abort = 0;
  logic [3:0] begin_num = 0, end_num = 0, req_addr;
  logic req_valid, req_ready = 1, rsp_valid = 0, busy, done, aborted, cfg_err, rsp_err;
  logic [4:0] packets_issued;
  int checks = 0, errors = 0;
  int fire_cnt = 0, done_cnt = 0, rsps_sent = 0, rel_req = 0, rel_done = 0;
  bit hold_rsp = 0, rand_ready = 0, force_rsp = 0;
  int exp_q[$];
  int base;
  analyzer_readback_ctrl #(.NUM_PACKETS(NP), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset), .start(start), .sampler_idle(sampler_idle),
    .read_all(read_all), .abort(abort), .begin_num(begin_num), .end_num(end_num),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .busy(busy), .done(done), .aborted(aborted),
    .cfg_err(cfg_err), .rsp_err(rsp_err), .packets_issued(packets_issued)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start_rb(input int b, input int e, input bit ra);
    int n = ra ? NP : ((e - b + NP) % NP) + 1;
    for (int i = 0; i < n; i++) exp_q.push_back((b + i) % NP);
    @(posedge clk); #1;
    start = 1; begin_num = 4'(b); end_num = 4'(e); read_all = ra;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(seen), 1);
  endtask
  task automatic wait_fires(input int n, input int limit);
    for (int i = 0; i < limit && fire_cnt - base < n; i++) @(negedge clk);
    check("fires_reached", 32'(fire_cnt - base >= n), 1);
  endtask
  task automatic check_reset_state();
    check("rst_busy", busy, 0);
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_done", done, 0);
    check("rst_aborted", aborted, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_packets", packets_issued, 0);
  endtask
  // monitor: scores every fire against the expected address stream
  initial begin
    logic pv;
    logic [3:0] pa;
    pv = 0; pa = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pv && req_valid) check("hold_addr", req_addr, pa);
        if (req_valid && req_ready) begin
          fire_cnt++;
          check("fire_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("addr", req_addr, exp_q.pop_front());
        end
        if (done) done_cnt++;
      end
      pv = !reset && req_valid && !req_ready;
      pa = req_addr;
    end
  end
  // memory model: ready pattern and one-cycle read responses
  initial forever begin
    @(posedge clk); #2;
    req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (force_rsp) rsp_valid = 1;
    else if (fire_cnt > rsps_sent && (!hold_rsp || rel_req > rel_done)) begin
      rsp_valid = 1;
      rsps_sent++;
      if (hold_rsp) rel_done++;
    end else rsp_valid = 0;
  end
  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    check_reset_state();
    base = done_cnt;
    start_rb(3, 6, 0);
    @(negedge clk);
    check("first_valid", req_valid, 1);
    check("first_addr", req_addr, 3);
    wait_done(100);
    check("basic_packets", packets_issued, 4);
    check("basic_aborted", aborted, 0);
    check("basic_drained", exp_q.size(), 0);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("single_done", done_cnt - base, 1);
    start_rb(8, 1, 0);
    wait_done(100);
    check("wrap_packets", packets_issued, 4);
    check("wrap_drained", exp_q.size(), 0);
    start_rb(7, 0, 1);
    wait_done(100);
    check("all_packets", packets_issued, 10);
    check("all_drained", exp_q.size(), 0);
    hold_rsp = 1;
    base = fire_cnt;
    start_rb(0, 9, 0);
    repeat (8) @(negedge clk);
    check("throttle_fires", fire_cnt - base, 2);
    check("throttle_valid", req_valid, 0);
    @(posedge clk); #1;
    rel_req++;
    @(negedge clk);
    check("throttle_rsp_cycle", req_valid, 0);
    @(negedge clk);
    check("throttle_reassert", req_valid, 1);
    repeat (4) @(negedge clk);
    check("throttle_one_more", fire_cnt - base, 3);
    check("throttle_valid2", req_valid, 0);
    hold_rsp = 0;
    wait_done(100);
    check("throttle_packets", packets_issued, 10);
    check("throttle_drained", exp_q.size(), 0);
    rand_ready = 1;
    start_rb(5, 4, 0);
    wait_done(400);
    rand_ready = 0;
    check("rand_packets", packets_issued, 10);
    check("rand_drained", exp_q.size(), 0);
    hold_rsp = 1;
    base = fire_cnt;
    start_rb(0, 9, 0);
    wait_fires(2, 50);
    @(posedge clk); #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    base = done_cnt;
    repeat (4) @(negedge clk);
    check("abort_busy", busy, 1);
    check("abort_no_done", done_cnt - base, 0);
    hold_rsp = 0;
    wait_done(100);
    check("abort_flag", aborted, 1);
    check("abort_packets", packets_issued, 2);
    exp_q.delete();
    @(posedge clk); #1;
    start = 1; begin_num = 10; end_num = 3; read_all = 0;
    @(negedge clk);
    check("cfg_err_begin", cfg_err, 1);
    @(posedge clk); #1 start = 0;
    @(negedge clk);
    check("cfg_err_busy", busy, 0);
    check("cfg_err_pulse", cfg_err, 0);
    check("aborted_held", aborted, 1);
    @(posedge clk); #1;
    start = 1; begin_num = 2; end_num = 12;
    @(negedge clk);
    check("cfg_err_end", cfg_err, 1);
    @(posedge clk); #1 start = 0;
    @(posedge clk); #1 force_rsp = 1;
    @(posedge clk); #1 force_rsp = 0;
    @(negedge clk);
    check("rsp_err_set", rsp_err, 1);
    start_rb(1, 1, 0);
    @(negedge clk);
    check("rsp_err_clear", rsp_err, 0);
    check("aborted_clear", aborted, 0);
    wait_done(100);
    check("one_packet", packets_issued, 1);
    base = fire_cnt;
    @(posedge clk); #1;
    sampler_idle = 0; start = 1; begin_num = 0; end_num = 3;
    @(posedge clk); #1;
    start = 0; sampler_idle = 1;
    repeat (3) @(negedge clk);
    check("not_idle_busy", busy, 0);
    check("not_idle_fires", fire_cnt - base, 0);
    base = fire_cnt;
    start_rb(0, 9, 0);
    wait_fires(3, 50);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    exp_q.delete();
    @(negedge clk);
    check_reset_state();
    repeat (4) @(negedge clk);
    check("stale_rsp_ignored", rsp_err, 0);
    start_rb(2, 5, 0);
    wait_done(100);
    check("post_reset_packets", packets_issued, 4);
    check("post_reset_aborted", aborted, 0);
    check("post_reset_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
